lcisc_mt_engine: RTL
====================

Name: lcisc_mt_engine

Overview:
- Parametrised multi-thread successor to the single-step lcisc thread executor.
- Holds NUM_THREADS independent thread contexts (PC, register file, status) that share one program memory.
- A round-robin scheduler issues one instruction per cycle from one running thread; each thread runs until its instruction budget is exhausted or it hits HALT.
- Sits between the job loader (start/init/program ports) and the result collector (done/readback ports).

Parameters:
- DATA_W, 32, register data width.
- NUM_REGS, 16, registers per thread (power of 2).
- CODE_DEPTH, 32, shared program memory depth in instructions (power of 2).
- NUM_THREADS, 4, number of thread contexts (power of 2, ≥2).
- LEN_W, 8, width of the instruction budget.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program memory write strobe.
- prog_addr  in  $clog2(CODE_DEPTH)  program write address.
- prog_instr  in  instr_t  instruction written.
- init_we  in  1  register init write strobe.
- init_tid  in  $clog2(NUM_THREADS)  target thread.
- init_reg  in  $clog2(NUM_REGS)  target register.
- init_data  in  DATA_W  data written.
- start_valid  in  1  start request.
- start_ready  out  1  start_tid is IDLE.
- start_tid  in  $clog2(NUM_THREADS)  thread to start.
- start_pc  in  $clog2(CODE_DEPTH)  first instruction address.
- start_len  in  LEN_W  instruction budget.
- done_valid  out  1  a thread is in DONE.
- done_ready  in  1  collector accepts.
- done_tid  out  $clog2(NUM_THREADS)  finished thread.
- done_halt  out  1  1 = ended by HALT, 0 = budget exhausted.
- done_div0  out  1  sticky divide-by-zero flag.
- done_pc  out  $clog2(CODE_DEPTH)  PC after the last executed instruction.
- rd_tid, rd_reg  in  per above  combinational register readback select.
- rd_data  out  DATA_W  selected register value.

Behaviour:
- Reset (async, rst_n=0):
  - All threads IDLE; all registers 0; PCs 0; budgets 0; div0 flags 0; round-robin pointer 0.
  - done_valid=0; start_ready=1.
  - Program memory is not reset.
- Opcodes: NOP, ADD, SUB, MUL, DIV, HALT.
  - Result is dest = op1 OP op2, truncated to DATA_W, unsigned.
  - DIV by 0: result all-ones and the thread's div0 flag is set (sticky until the next start).
  - dest==op1 or dest==op2 reads the old value.
- Thread FSM per context:
  - IDLE→RUN on a start handshake (start_valid & start_ready). The handshake loads PC=start_pc and budget=start_len and clears div0.
  - IDLE→DONE directly if start_len==0 (done_halt=0, PC unchanged).
  - RUN→DONE after the issue that decrements the budget to 0, or on issue of HALT. HALT consumes budget and does not write; PC still increments.
  - DONE→IDLE on a done handshake for that tid.
- start_ready = (state[start_tid]==IDLE), combinational. A start to a busy thread stalls and is not dropped.
- Scheduler:
  - Each cycle selects the first RUN thread at or after the pointer (modulo NUM_THREADS).
  - Fetches code[pc], executes, and writes dest at the clock edge; PC increments by 1.
  - The pointer moves to selected+1.
  - No RUN thread: no issue, pointer held.
  - Throughput: one instruction/cycle aggregate, one per NUM_THREADS cycles per thread when all run.
- Latency:
  - A start accepted at edge T allows the first issue at the earliest in the cycle after T.
  - A thread enters DONE at the edge of its final issue; done_valid is seen the following cycle.
- PC wraps from CODE_DEPTH-1 to 0.
- done output:
  - Presents the lowest-index DONE thread.
  - Fields are stable while done_valid & !done_ready.
  - A lower-index thread reaching DONE while another is presented does not preempt it; the current tid is held until accepted.
- init_we:
  - Writes only if init_tid is IDLE or DONE; silently dropped for RUN.
  - Same-edge init and start for one thread: the init write lands and the start is accepted.
- prog_we:
  - Same-cycle write and fetch of the same address fetches the old contents.
  - Writes while threads run are legal.
- Register writes: at most one execute write per cycle, no conflict with init (disjoint states).
- rd_data is combinational from the current register state, for any thread state.
- Reset mid-run aborts all threads; no done is reported.

Decomposition:
- Shared package my_pkg:
  - opcode_e extended with NOP and HALT.
  - instr_t {opcode, dest, operand1, operand2}, index widths derived from package constants.
  - thr_state_e {IDLE, RUN, DONE}.
- Sub-module lcisc_alu: combinational, opcode + two operands → result + div0.
- Round-robin selection stays inline.

Test Plan:
- Single run: tid0 init r1=7, r2=5, code[0]=ADD r3,r1,r2, code[1]=MUL r4,r3,r3, start pc=0 len=2 → done tid0, halt=0, pc=2; r3=12, r4=144.
- HALT/budget: code[5]=SUB r0,r1,r2 (r1=3, r2=5), code[6]=HALT, len=10 → r0=0xFFFFFFFE, done_halt=1, pc=7.
- Divide by zero: DIV r1,r2,r3 with r3=0 → r1=0xFFFFFFFF, done_div0=1. A restart clears the flag.
- Fairness: 4 threads, each len=3 at t=0 → issue order 0,1,2,3,0,1,2,3,…; with done_ready held low, all four reach DONE; done_tid=0 first, then 1,2,3 on successive handshakes.
- Backpressure/stall: start tid1 while tid1 is RUN → start_ready=0 until tid1's done is accepted; init to the running tid1 is dropped.
- Edge cases: start len=0 → done the next cycle, pc unchanged. PC wrap: pc=31, len=2 → done_pc=1. Async reset mid-run → done_valid=0 and registers read 0 immediately.

Source files
------------

// File: rtl/lcisc_mt_engine_pkg.sv
// Shared types for the multi-thread lcisc engine: instruction format, opcodes and
// per-thread context states.
package lcisc_mt_engine_pkg;

    localparam int unsigned NumRegsDef = 16;
    localparam int unsigned RegIdxW    = $clog2(NumRegsDef);

    typedef enum logic [2:0] {
        OpNop  = 3'd0,
        OpAdd  = 3'd1,
        OpSub  = 3'd2,
        OpMul  = 3'd3,
        OpDiv  = 3'd4,
        OpHalt = 3'd5
    } opcode_e;

    typedef struct packed {
        opcode_e              opcode;
        logic [RegIdxW-1:0]   dest;
        logic [RegIdxW-1:0]   operand1;
        logic [RegIdxW-1:0]   operand2;
    } instr_t;

    typedef enum logic [1:0] {
        ThrIdle,
        ThrRun,
        ThrDone
    } thr_state_e;

    function automatic logic writes_reg(opcode_e op);
        return (op == OpAdd) || (op == OpSub) || (op == OpMul) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/lcisc_mt_engine_alu.sv
// Combinational lcisc ALU: unsigned add/sub/mul/div truncated to DATA_W.
// Division by zero yields all-ones and raises div0_o.
module lcisc_alu
    import lcisc_mt_engine_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  opcode_e           opcode_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              div0_o
);

    always_comb begin
        result_o = '0;
        div0_o   = 1'b0;
        case (opcode_i)
            OpAdd: result_o = a_i + b_i;
            OpSub: result_o = a_i - b_i;
            OpMul: result_o = a_i * b_i;
            OpDiv: begin
                if (b_i == '0) begin
                    result_o = '1;
                    div0_o   = 1'b1;
                end else begin
                    result_o = a_i / b_i;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcisc_mt_engine.sv
// Multi-thread lcisc executor: NUM_THREADS contexts sharing one program memory,
// round-robin issue of one instruction per cycle, done reporting with hold-until-accept.
module lcisc_mt_engine
    import lcisc_mt_engine_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned CODE_DEPTH  = 32,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned LEN_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           prog_we,
    input  logic [$clog2(CODE_DEPTH)-1:0]  prog_addr,
    input  instr_t                         prog_instr,
    input  logic                           init_we,
    input  logic [$clog2(NUM_THREADS)-1:0] init_tid,
    input  logic [$clog2(NUM_REGS)-1:0]    init_reg,
    input  logic [DATA_W-1:0]              init_data,
    input  logic                           start_valid,
    output logic                           start_ready,
    input  logic [$clog2(NUM_THREADS)-1:0] start_tid,
    input  logic [$clog2(CODE_DEPTH)-1:0]  start_pc,
    input  logic [LEN_W-1:0]               start_len,
    output logic                           done_valid,
    input  logic                           done_ready,
    output logic [$clog2(NUM_THREADS)-1:0] done_tid,
    output logic                           done_halt,
    output logic                           done_div0,
    output logic [$clog2(CODE_DEPTH)-1:0]  done_pc,
    input  logic [$clog2(NUM_THREADS)-1:0] rd_tid,
    input  logic [$clog2(NUM_REGS)-1:0]    rd_reg,
    output logic [DATA_W-1:0]              rd_data
);

    localparam int unsigned PC_W  = $clog2(CODE_DEPTH);
    localparam int unsigned TID_W = $clog2(NUM_THREADS);

    instr_t            code_q [CODE_DEPTH];
    logic [DATA_W-1:0] regs_q [NUM_THREADS][NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_THREADS][NUM_REGS];
    thr_state_e        state_q [NUM_THREADS];
    thr_state_e        state_d [NUM_THREADS];
    logic [PC_W-1:0]   pc_q [NUM_THREADS];
    logic [PC_W-1:0]   pc_d [NUM_THREADS];
    logic [LEN_W-1:0]  len_q [NUM_THREADS];
    logic [LEN_W-1:0]  len_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] div0_q, div0_d, halt_q, halt_d;
    logic [TID_W-1:0]  ptr_q, ptr_d;
    logic              pres_q, pres_d;
    logic [TID_W-1:0]  pres_tid_q, pres_tid_d;

    logic              issue;
    logic [TID_W-1:0]  sel;
    logic [TID_W-1:0]  low_tid;
    instr_t            instr;
    logic [DATA_W-1:0] alu_result;
    logic              alu_div0;
    logic              start_fire, done_fire;

    always_ff @(posedge clk) begin
        if (prog_we) begin
            code_q[prog_addr] <= prog_instr;
        end
    end

    // First RUN thread at or after the pointer; TID_W arithmetic wraps the search.
    always_comb begin
        issue = 1'b0;
        sel   = ptr_q;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            if (!issue && state_q[ptr_q + TID_W'(i)] == ThrRun) begin
                issue = 1'b1;
                sel   = ptr_q + TID_W'(i);
            end
        end
    end

    always_comb begin
        done_valid = 1'b0;
        low_tid    = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (state_q[i] == ThrDone) begin
                done_valid = 1'b1;
                low_tid    = TID_W'(i);
            end
        end
    end

    assign instr       = code_q[pc_q[sel]];
    assign start_ready = (state_q[start_tid] == ThrIdle);
    assign start_fire  = start_valid && start_ready;
    // A presented thread stays presented until accepted, even if a lower tid finishes.
    assign done_tid    = pres_q ? pres_tid_q : low_tid;
    assign done_fire   = done_valid && done_ready;
    assign done_halt   = halt_q[done_tid];
    assign done_div0   = div0_q[done_tid];
    assign done_pc     = pc_q[done_tid];
    assign rd_data     = regs_q[rd_tid][rd_reg];

    lcisc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode_i (instr.opcode),
        .a_i      (regs_q[sel][instr.operand1]),
        .b_i      (regs_q[sel][instr.operand2]),
        .result_o (alu_result),
        .div0_o   (alu_div0)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        div0_d     = div0_q;
        halt_d     = halt_q;
        regs_d     = regs_q;
        ptr_d      = ptr_q;
        pres_d     = done_valid && !done_ready;
        pres_tid_d = done_tid;

        if (issue) begin
            ptr_d      = sel + TID_W'(1);
            pc_d[sel]  = pc_q[sel] + PC_W'(1);
            len_d[sel] = len_q[sel] - LEN_W'(1);
            if (alu_div0) begin
                div0_d[sel] = 1'b1;
            end
            if (writes_reg(instr.opcode)) begin
                regs_d[sel][instr.dest] = alu_result;
            end
            if (instr.opcode == OpHalt || len_q[sel] == LEN_W'(1)) begin
                state_d[sel] = ThrDone;
                halt_d[sel]  = (instr.opcode == OpHalt);
            end
        end

        // Issue, done and start act on threads in disjoint states, so no overlap.
        if (done_fire) begin
            state_d[done_tid] = ThrIdle;
        end

        if (start_fire) begin
            pc_d[start_tid]    = start_pc;
            len_d[start_tid]   = start_len;
            div0_d[start_tid]  = 1'b0;
            halt_d[start_tid]  = 1'b0;
            state_d[start_tid] = (start_len == '0) ? ThrDone : ThrRun;
        end

        if (init_we && state_q[init_tid] != ThrRun) begin
            regs_d[init_tid][init_reg] = init_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state_q[t] <= ThrIdle;
                pc_q[t]    <= '0;
                len_q[t]   <= '0;
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs_q[t][r] <= '0;
                end
            end
            div0_q     <= '0;
            halt_q     <= '0;
            ptr_q      <= '0;
            pres_q     <= 1'b0;
            pres_tid_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            regs_q     <= regs_d;
            div0_q     <= div0_d;
            halt_q     <= halt_d;
            ptr_q      <= ptr_d;
            pres_q     <= pres_d;
            pres_tid_q <= pres_tid_d;
        end
    end

endmodule
